// File: rtl/svm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | svm_pkg : shared widths, cascade FSM encoding and class constants         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package svm_pkg;

  localparam int XLEN_PIXEL    = 8;
  localparam int NUM_OF_PIXELS = 784;
  localparam int SCORE_W       = 5 * XLEN_PIXEL;

  typedef enum logic [2:0] {
    ST_CAPTURE    = 3'd0,
    ST_WAIT_SCORE = 3'd1,
    ST_DECIDE     = 3'd2,
    ST_REPLAY     = 3'd3,
    ST_WAIT_S2    = 3'd4,
    ST_EMIT       = 3'd5
  } cascade_state_t;

  localparam logic CLASS_POS = 1'b1;
  localparam logic CLASS_NEG = 1'b0;

endpackage
`default_nettype wire

// File: rtl/cascade_gate_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cascade_gate_if : replay stream and verdict return between gate/stage 2   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface cascade_gate_if
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL = svm_pkg::XLEN_PIXEL
);

  logic                  s2_start;
  logic                  s2_pix_valid;
  logic [XLEN_PIXEL-1:0] s2_pix;
  logic                  s2_pix_ready;
  logic                  s2_class_valid;
  logic                  s2_class;

  modport master (
    output s2_start,
    output s2_pix_valid,
    output s2_pix,
    input  s2_pix_ready,
    input  s2_class_valid,
    input  s2_class
  );

  modport slave (
    input  s2_start,
    input  s2_pix_valid,
    input  s2_pix,
    output s2_pix_ready,
    output s2_class_valid,
    output s2_class
  );

endinterface
`default_nettype wire

// File: rtl/pixel_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_buf : single-port image RAM with one-cycle registered read          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pixel_buf
  import svm_pkg::*;
#(
  parameter int DEPTH  = NUM_OF_PIXELS,
  parameter int WIDTH  = XLEN_PIXEL,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  din_i,
  output logic [WIDTH-1:0]  dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  // Output register reset maps onto the block-RAM output latch reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (re_i) begin
      dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/cascade_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cascade_gate : buffers the image, resolves confident stage-1 scores and   |
// | replays uncertain images into stage 2.            Revision: 1.0           |
// +--------------------------------------------------------------------------+
module cascade_gate
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL    = svm_pkg::XLEN_PIXEL,
  parameter int NUM_OF_PIXELS = svm_pkg::NUM_OF_PIXELS,
  parameter int SCORE_W       = svm_pkg::SCORE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_in_valid,
  input  logic [XLEN_PIXEL-1:0]     pix_in,
  output logic                      cap_ready,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score,
  input  logic signed [SCORE_W-1:0] thr_pos,
  input  logic signed [SCORE_W-1:0] thr_neg,
  cascade_gate_if.master            s2_bus,
  output logic                      class_valid,
  output logic                      class_out,
  output logic                      class_stage,
  output logic [15:0]               n_deferred
);

  localparam int CNT_W = $clog2(NUM_OF_PIXELS);
  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(NUM_OF_PIXELS - 1);
  localparam logic [CNT_W-1:0] c_NPIX     = CNT_W'(NUM_OF_PIXELS);

  cascade_state_t            state_q, state_d;
  logic [CNT_W-1:0]          pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic signed [SCORE_W-1:0] score_q, score_d;
  logic                      score_pend_q, score_pend_d;
  logic                      s2_start_q, s2_start_d;
  logic                      pix_valid_q, pix_valid_d;
  logic                      class_out_q, class_out_d;
  logic                      class_stage_q, class_stage_d;
  logic [15:0]               n_def_q, n_def_d;

  logic                      buf_we;
  logic                      buf_re;
  logic [CNT_W-1:0]          buf_addr;
  logic                      rd_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CAPTURE;
      pix_cnt_q     <= '0;
      rd_ptr_q      <= '0;
      score_q       <= '0;
      score_pend_q  <= 1'b0;
      s2_start_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      class_out_q   <= 1'b0;
      class_stage_q <= 1'b0;
      n_def_q       <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      score_q       <= score_d;
      score_pend_q  <= score_pend_d;
      s2_start_q    <= s2_start_d;
      pix_valid_q   <= pix_valid_d;
      class_out_q   <= class_out_d;
      class_stage_q <= class_stage_d;
      n_def_q       <= n_def_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    score_d       = score_q;
    score_pend_d  = score_pend_q;
    s2_start_d    = 1'b0;
    pix_valid_d   = pix_valid_q;
    class_out_d   = class_out_q;
    class_stage_d = class_stage_q;
    n_def_d       = n_def_q;
    buf_we        = 1'b0;
    buf_re        = 1'b0;
    buf_addr      = pix_cnt_q;
    // A new read may be issued whenever the output slot is empty or draining.
    rd_issue      = (!pix_valid_q || s2_bus.s2_pix_ready) && (rd_ptr_q != c_NPIX);

    case (state_q)
      ST_CAPTURE: begin
        if (score_valid) begin
          score_d      = score;
          score_pend_d = 1'b1;
        end
        if (pix_in_valid) begin
          buf_we    = 1'b1;
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_q == c_LAST_IDX) begin
            state_d = (score_pend_q || score_valid) ? ST_DECIDE : ST_WAIT_SCORE;
          end
        end
      end

      ST_WAIT_SCORE: begin
        if (score_valid) begin
          score_d      = score;
          score_pend_d = 1'b1;
        end
        if (score_pend_q || score_valid) begin
          state_d = ST_DECIDE;
        end
      end

      ST_DECIDE: begin
        if (score_q >= thr_pos) begin
          class_out_d   = CLASS_POS;
          class_stage_d = 1'b0;
          state_d       = ST_EMIT;
        end else if (score_q <= thr_neg) begin
          class_out_d   = CLASS_NEG;
          class_stage_d = 1'b0;
          state_d       = ST_EMIT;
        end else begin
          s2_start_d = 1'b1;
          rd_ptr_d   = '0;
          if (n_def_q != 16'hFFFF) begin
            n_def_d = n_def_q + 16'd1;
          end
          state_d = ST_REPLAY;
        end
      end

      ST_REPLAY: begin
        buf_addr = rd_ptr_q;
        if (rd_issue) begin
          buf_re      = 1'b1;
          rd_ptr_d    = rd_ptr_q + CNT_W'(1);
          pix_valid_d = 1'b1;
        end else if (pix_valid_q && s2_bus.s2_pix_ready) begin
          // Only reachable once every address has been read out.
          pix_valid_d = 1'b0;
          state_d     = ST_WAIT_S2;
        end
      end

      ST_WAIT_S2: begin
        if (s2_bus.s2_class_valid) begin
          class_out_d   = s2_bus.s2_class;
          class_stage_d = 1'b1;
          state_d       = ST_EMIT;
        end
      end

      ST_EMIT: begin
        pix_cnt_d    = '0;
        score_pend_d = 1'b0;
        state_d      = ST_CAPTURE;
      end

      default: begin
        state_d = ST_CAPTURE;
      end
    endcase
  end

  pixel_buf #(
    .DEPTH  (NUM_OF_PIXELS),
    .WIDTH  (XLEN_PIXEL),
    .ADDR_W (CNT_W)
  ) u_pixel_buf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (buf_we),
    .re_i   (buf_re),
    .addr_i (buf_addr),
    .din_i  (pix_in),
    .dout_o (s2_bus.s2_pix)
  );

  assign cap_ready           = (state_q == ST_CAPTURE);
  assign class_valid         = (state_q == ST_EMIT);
  assign class_out           = class_out_q;
  assign class_stage         = class_stage_q;
  assign n_deferred          = n_def_q;
  assign s2_bus.s2_start     = s2_start_q;
  assign s2_bus.s2_pix_valid = pix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cascade_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cascade_gate : table-driven check of capture, decide, replay, reset    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cascade_gate;
  import svm_pkg::*;

  localparam int NPIX = 784;

  typedef struct {
    logic signed [39:0] score;
    int                 score_at;   // pixel index carrying score_valid; NPIX = after capture
    logic signed [39:0] thr_pos;
    logic signed [39:0] thr_neg;
    bit                 defer;
    bit                 s2_cls;
    bit                 exp_cls;
    int                 pat;
    bit                 rnd_rdy;
    bit                 decoy_en;
    logic signed [39:0] decoy;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     pix_in_valid;
  logic [7:0]               pix_in;
  logic                     cap_ready;
  logic                     score_valid;
  logic signed [39:0]       score;
  logic signed [39:0]       thr_pos;
  logic signed [39:0]       thr_neg;
  logic                     class_valid;
  logic                     class_out;
  logic                     class_stage;
  logic [15:0]              n_deferred;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_cv = 0;
  int exp_ndef = 0;
  vec_t tbl[10];

  cascade_gate_if #(.XLEN_PIXEL(8)) s2_if ();

  cascade_gate dut (
    .clk          (clk),
    .rst          (rst),
    .pix_in_valid (pix_in_valid),
    .pix_in       (pix_in),
    .cap_ready    (cap_ready),
    .score_valid  (score_valid),
    .score        (score),
    .thr_pos      (thr_pos),
    .thr_neg      (thr_neg),
    .s2_bus       (s2_if),
    .class_valid  (class_valid),
    .class_out    (class_out),
    .class_stage  (class_stage),
    .n_deferred   (n_deferred)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s2_if.s2_start) n_start++;
    if (class_valid)    n_cv++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_px(input int pat, input int i);
    if (pat == 0) return i[7:0];
    return 8'((i * 7 + 3) % 256);
  endfunction

  function automatic vec_t mk(input logic signed [39:0] sc, input int at,
                              input logic signed [39:0] tp, input logic signed [39:0] tn,
                              input bit df, input bit s2c, input bit ec, input int pt,
                              input bit rr, input bit de, input logic signed [39:0] dc);
    vec_t v;
    v.score = sc; v.score_at = at; v.thr_pos = tp; v.thr_neg = tn;
    v.defer = df; v.s2_cls = s2c; v.exp_cls = ec; v.pat = pt;
    v.rnd_rdy = rr; v.decoy_en = de; v.decoy = dc;
    return v;
  endfunction

  // Streams one image and delivers the score; returns just after the completing edge.
  task automatic stream(input vec_t v);
    thr_pos = v.thr_pos;
    thr_neg = v.thr_neg;
    for (int i = 0; i < NPIX; i++) begin
      pix_in_valid         = 1'b1;
      pix_in               = pat_px(v.pat, i);
      score_valid          = 1'b0;
      s2_if.s2_class_valid = (i == 1);  // stray verdict during capture must be ignored
      s2_if.s2_class       = 1'b1;
      if (v.decoy_en && i == 3) begin
        score_valid = 1'b1;
        score       = v.decoy;
      end
      if (i == v.score_at) begin
        score_valid = 1'b1;
        score       = v.score;
      end
      tick();
    end
    pix_in_valid         = 1'b0;
    score_valid          = 1'b0;
    s2_if.s2_class_valid = 1'b0;
    if (v.score_at >= NPIX) begin
      chk("cap_ready_wait", cap_ready, 0);
      score_valid = 1'b1;
      score       = v.score;
      tick();
      score_valid = 1'b0;
    end
  endtask

  // Drives s2_pix_ready and checks the replayed stream until `limit` handshakes.
  task automatic replay(input int pat, input bit rnd, input int limit, output int got);
    int data_err = 0;
    int hold_err = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_pix = '0;
    got = 0;
    for (int cyc = 0; cyc < 8000 && got < limit; cyc++) begin
      if (prev_stall && (!s2_if.s2_pix_valid || s2_if.s2_pix !== prev_pix)) hold_err++;
      s2_if.s2_pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s2_if.s2_pix_valid && s2_if.s2_pix_ready) begin
        if (s2_if.s2_pix !== pat_px(pat, got)) data_err++;
        got++;
      end
      prev_stall = s2_if.s2_pix_valid && !s2_if.s2_pix_ready;
      prev_pix   = s2_if.s2_pix;
      if (got < limit) tick();
    end
    chk("replay_data_err", data_err, 0);
    chk("replay_hold_err", hold_err, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int st0 = n_start;
    int cv0 = n_cv;
    int got;
    chk($sformatf("v%0d_cap_ready", idx), cap_ready, 1);
    stream(v);
    chk($sformatf("v%0d_cv_early", idx), class_valid, 0);
    tick();
    if (!v.defer) begin
      chk($sformatf("v%0d_class_valid", idx), class_valid, 1);
      chk($sformatf("v%0d_class_out", idx), class_out, v.exp_cls);
      chk($sformatf("v%0d_class_stage", idx), class_stage, 0);
    end else begin
      exp_ndef++;
      chk($sformatf("v%0d_s2_start", idx), s2_if.s2_start, 1);
      chk($sformatf("v%0d_pix_valid_first", idx), s2_if.s2_pix_valid, 0);
      replay(v.pat, v.rnd_rdy, NPIX, got);
      tick();
      chk($sformatf("v%0d_replay_count", idx), got, NPIX);
      chk($sformatf("v%0d_pix_valid_end", idx), s2_if.s2_pix_valid, 0);
      s2_if.s2_pix_ready = 1'b0;
      tick();
      tick();
      chk($sformatf("v%0d_cv_wait", idx), class_valid, 0);
      s2_if.s2_class_valid = 1'b1;
      s2_if.s2_class       = v.s2_cls;
      tick();
      s2_if.s2_class_valid = 1'b0;
      chk($sformatf("v%0d_class_valid", idx), class_valid, 1);
      chk($sformatf("v%0d_class_out", idx), class_out, v.s2_cls);
      chk($sformatf("v%0d_class_stage", idx), class_stage, 1);
    end
    tick();
    chk($sformatf("v%0d_cv_after", idx), class_valid, 0);
    chk($sformatf("v%0d_cap_ready_after", idx), cap_ready, 1);
    chk($sformatf("v%0d_n_deferred", idx), n_deferred, exp_ndef);
    chk($sformatf("v%0d_start_pulses", idx), n_start - st0, v.defer ? 1 : 0);
    chk($sformatf("v%0d_cv_pulses", idx), n_cv - cv0, 1);
  endtask

  initial begin
    int got;
    tbl[0] = mk( 500,   0,  100, -100, 0, 0, 1, 0, 0, 0, 0);
    tbl[1] = mk(-500, 783,  100, -100, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(   0, 784,  100, -100, 1, 1, 1, 0, 0, 0, 0);
    tbl[3] = mk( 100, 200,  100, -100, 0, 0, 1, 0, 0, 0, 0);
    tbl[4] = mk(-100, 784,  100, -100, 0, 0, 0, 0, 0, 0, 0);
    tbl[5] = mk(   0,  50,    0,    0, 0, 0, 1, 0, 0, 0, 0);
    tbl[6] = mk(  50, 400,  100, -100, 1, 0, 0, 1, 1, 1, 500);
    tbl[7] = mk(   0, 783,  -10,   10, 0, 0, 1, 0, 0, 0, 0);
    tbl[8] = mk(40'sh80_0000_0000, 10, 100, -1, 0, 0, 0, 0, 0, 0, 0);
    tbl[9] = mk(40'sh10_0000_0000, 10, 40'sh0F_FFFF_FFFF, -1, 0, 0, 1, 0, 0, 0, 0);

    rst = 1'b1; pix_in_valid = 1'b0; pix_in = '0; score_valid = 1'b0; score = '0;
    thr_pos = '0; thr_neg = '0;
    s2_if.s2_pix_ready = 1'b0; s2_if.s2_class_valid = 1'b0; s2_if.s2_class = 1'b0;
    repeat (3) tick();
    chk("rst_cap_ready", cap_ready, 1);
    chk("rst_s2_start", s2_if.s2_start, 0);
    chk("rst_pix_valid", s2_if.s2_pix_valid, 0);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_class_out", class_out, 0);
    chk("rst_class_stage", class_stage, 0);
    chk("rst_s2_pix", s2_if.s2_pix, 0);
    chk("rst_n_deferred", n_deferred, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 10; k++) run_vec(k, tbl[k]);

    // Abort a replay after 300 handshakes with reset.
    begin
      int cv0;
      stream(tbl[2]);
      tick();
      cv0 = n_cv;
      replay(0, 1'b0, 300, got);
      rst = 1'b1;
      tick();
      chk("midrst_cap_ready", cap_ready, 1);
      chk("midrst_s2_start", s2_if.s2_start, 0);
      chk("midrst_pix_valid", s2_if.s2_pix_valid, 0);
      chk("midrst_s2_pix", s2_if.s2_pix, 0);
      chk("midrst_class_valid", class_valid, 0);
      chk("midrst_class_out", class_out, 0);
      chk("midrst_class_stage", class_stage, 0);
      chk("midrst_n_deferred", n_deferred, 0);
      rst = 1'b0;
      s2_if.s2_pix_ready = 1'b0;
      repeat (3) tick();
      chk("midrst_no_pix", s2_if.s2_pix_valid, 0);
      chk("midrst_no_cv", n_cv - cv0, 0);
      exp_ndef = 0;
    end
    run_vec(10, tbl[0]);
    run_vec(11, tbl[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cascade_gate.md
# cascade_gate

Sits directly downstream of the stage-1 SVM classifier. It captures the 784-pixel test image as it streams into stage 1, then takes the stage-1 decision score. Confident scores resolve the class immediately; scores inside the uncertainty band trigger a replay of the buffered image into stage 2, whose verdict is forwarded instead. It also counts how many images were deferred to stage 2.

## Interface
Parameters:
- XLEN_PIXEL, 8, pixel width
- NUM_OF_PIXELS, 784, pixels per image
- SCORE_W, 40, stage-1 signed score width (5*XLEN_PIXEL)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- pix_in_valid  in  1  pixel strobe of the image fed to stage 1
- pix_in  in  XLEN_PIXEL  pixel value
- cap_ready  out  1  high when a pixel is accepted (state CAPTURE)
- score_valid  in  1  one-cycle strobe, stage-1 score available
- score  in  SCORE_W  stage-1 decision value, two's complement
- thr_pos, thr_neg  in  SCORE_W each  signed confidence thresholds
- s2_start  out  1  one-cycle pulse opening a stage-2 replay
- s2_pix_valid  out  1  replay pixel valid
- s2_pix  out  XLEN_PIXEL  replay pixel
- s2_pix_ready  in  1  stage 2 accepts replay pixel
- s2_class_valid  in  1  stage-2 verdict strobe
- s2_class  in  1  stage-2 verdict
- class_valid  out  1  one-cycle pulse, final class available
- class_out  out  1  final class, 1 = positive
- class_stage  out  1  0 = resolved by stage 1, 1 = by stage 2
- n_deferred  out  16  saturating count of images sent to stage 2

## Operation
- States: CAPTURE, WAIT_SCORE, DECIDE, REPLAY, WAIT_S2, EMIT.
- CAPTURE: accepts a pixel when pix_in_valid && cap_ready. The pixel is written to the buffer at address pix_cnt, and pix_cnt increments. Accepting pixel NUM_OF_PIXELS-1 moves the FSM to WAIT_SCORE.
- A score_valid seen in CAPTURE or WAIT_SCORE latches score and sets score_pend. The FSM enters DECIDE on the first cycle where the capture is complete and score_pend is set, including when both events occur in the same cycle. A second score_valid before DECIDE overwrites the first.
- DECIDE, checked in this order:
  - score >= thr_pos gives class 1, stage 0, then EMIT.
  - score <= thr_neg gives class 0, stage 0, then EMIT.
  - Otherwise: s2_start pulses, n_deferred increments (saturating at 0xFFFF), then REPLAY.
- If thr_pos <= thr_neg, the positive check wins.
- REPLAY: streams addresses 0..NUM_OF_PIXELS-1 in order with a valid/ready handshake.
  - s2_pix and s2_pix_valid hold stable while s2_pix_ready is low.
  - After the last pixel's handshake, the FSM goes to WAIT_S2.
- WAIT_S2: s2_class_valid latches class_out = s2_class, class_stage = 1, then EMIT. An s2_class_valid in any other state is ignored.
- EMIT: class_valid = 1 for exactly one cycle, pix_cnt and score_pend clear, then CAPTURE.
- Pixels offered outside CAPTURE are not accepted (cap_ready = 0). The upstream must hold them.
- Arithmetic: all comparisons are signed, full SCORE_W; no truncation. Counters are $clog2(NUM_OF_PIXELS) bits wide.

## Timing
- Reset values:
  - state CAPTURE, cap_ready 1.
  - s2_start, s2_pix_valid, class_valid, class_out, class_stage: 0.
  - s2_pix 0, n_deferred 0, pix_cnt 0, score_pend 0.
- rst mid-operation (any state, including mid-replay) aborts at the next edge: no class_valid, no further s2 traffic. Buffer contents are don't-care.
- Confident path: DECIDE one cycle after the completing event, class_valid one cycle later. Example: last pixel at cycle t, score already pending → DECIDE at t+1, class_valid at t+2.
- Deferred path: s2_start registered in the DECIDE cycle, visible the next cycle. The first s2_pix_valid comes one cycle after s2_start, covering the buffer's read latency.
- Replay with s2_pix_ready held high sustains 1 pixel/cycle, so it completes in NUM_OF_PIXELS cycles.
- class_valid follows s2_class_valid by 1 cycle (latch, then EMIT).
- cap_ready returns high the cycle after class_valid.

## Structure
- Shared package `svm_pkg`:
  - XLEN_PIXEL, NUM_OF_PIXELS, SCORE_W defaults
  - FSM state encoding (cascade_state_t)
  - CLASS_POS/CLASS_NEG constants
- Sub-module `pixel_buf`: single-port synchronous RAM, NUM_OF_PIXELS × XLEN_PIXEL, 1-cycle registered read, write enable. Infers BRAM.

## Test plan
- Stream 784 pixels, score = +500, thr_pos = +100, thr_neg = -100 → class_valid 2 cycles after the last pixel; class_out 1, class_stage 0, no s2_start, n_deferred 0.
- Score = -500 arriving in the same cycle as the last pixel → DECIDE next cycle; class_out 0, class_stage 0.
- Pixels = address mod 256, score = 0 → s2_start pulse; replay yields 0,1,…,255,0,…; n_deferred 1. Then s2_class_valid with s2_class = 1 → class_out 1, class_stage 1.
- Replay with s2_pix_ready toggling randomly (~50%) → 784 handshakes in order, s2_pix stable while stalled, no duplicates or drops.
- Assert rst at replay pixel 300 → all outputs at reset values next cycle. A fresh image then classifies correctly; n_deferred 0.
- Score = thr_pos exactly → class 1. Score = thr_neg exactly → class 0. thr_pos = thr_neg = 0 with score 0 → class 1.
